control_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/cs_decode.sv | 68 ++++++
 rtl/control_unit.sv | 66 ++++++
 tb/tb_control_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit datapath: control-word bit map, opcodes and
// the sequencer state encoding.
package cpu_pkg;

  localparam int CS_W = 28;

  localparam int CS_ADD      = 0;
  localparam int CS_COMP     = 1;
  localparam int CS_SUB      = 2;
  localparam int CS_XORR     = 3;
  localparam int CS_ANDD     = 4;
  localparam int CS_ORR      = 5;
  localparam int CS_PC_OUT   = 6;
  localparam int CS_PC_INC   = 7;
  localparam int CS_PC_IN    = 8;
  localparam int CS_MAR_IN   = 9;
  localparam int CS_MEM_RD   = 10;
  localparam int CS_IR_IN    = 11;
  localparam int CS_ACC_IN   = 12;
  localparam int CS_ACC_OUT  = 13;
  localparam int CS_Z_OUT    = 25;
  localparam int CS_FLAG_OUT = 26;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_CMP = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH0,
    ST_FETCH1,
    ST_DECODE,
    ST_OPRD,
    ST_WB,
    ST_HALT
  } state_e;

  // Instructions that finish in DECODE without reading an immediate byte.
  function automatic logic skips_operand(input logic [3:0] op, input logic zf);
    return (op == OP_NOP) || (op inside {[4'hA:4'hE]}) || ((op == OP_JZ) && !zf);
  endfunction

  // ALU ops whose result is written back through Z; CMP only updates flags.
  function automatic logic needs_wb(input logic [3:0] op);
    return op inside {OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_OR};
  endfunction

endpackage

// File: rtl/cs_decode.sv
// Combinational control-word generator: maps sequencer state, latched opcode,
// zero flag and memory handshake onto the one-hot-per-function control bus.
module cs_decode
  import cpu_pkg::*;
#(
  parameter int SZ = CS_W
) (
  input  state_e          state,
  input  logic [3:0]      opcode,
  input  logic            zf,
  input  logic            mem_ready,
  output logic [SZ-1:0]   cs_bus,
  output logic            halt
);

  always_comb begin
    cs_bus = '0;
    halt   = 1'b0;
    unique case (state)
      ST_FETCH0: begin
        cs_bus[CS_PC_OUT] = 1'b1;
        cs_bus[CS_MAR_IN] = 1'b1;
      end
      ST_FETCH1: begin
        cs_bus[CS_MEM_RD] = 1'b1;
        if (mem_ready) begin
          cs_bus[CS_IR_IN]  = 1'b1;
          cs_bus[CS_PC_INC] = 1'b1;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_HLT) begin
          cs_bus = '0;
        end else if (skips_operand(opcode, zf)) begin
          cs_bus[CS_PC_INC] = 1'b1;
        end else begin
          cs_bus[CS_PC_OUT] = 1'b1;
          cs_bus[CS_MAR_IN] = 1'b1;
        end
      end
      ST_OPRD: begin
        cs_bus[CS_MEM_RD] = 1'b1;
        // A JZ only reaches OPRD when taken, so pc_in needs no zf term here.
        if (mem_ready) begin
          cs_bus[CS_PC_INC] = 1'b1;
          case (opcode)
            OP_ADD:         cs_bus[CS_ADD]    = 1'b1;
            OP_SUB:         cs_bus[CS_SUB]    = 1'b1;
            OP_CMP:         cs_bus[CS_COMP]   = 1'b1;
            OP_XOR:         cs_bus[CS_XORR]   = 1'b1;
            OP_AND:         cs_bus[CS_ANDD]   = 1'b1;
            OP_OR:          cs_bus[CS_ORR]    = 1'b1;
            OP_LDI:         cs_bus[CS_ACC_IN] = 1'b1;
            OP_JMP, OP_JZ:  cs_bus[CS_PC_IN]  = 1'b1;
            default:        cs_bus[CS_PC_INC] = 1'b1;
          endcase
        end
      end
      ST_WB: begin
        cs_bus[CS_Z_OUT]  = 1'b1;
        cs_bus[CS_ACC_IN] = 1'b1;
      end
      ST_HALT: halt = 1'b1;
      default: cs_bus = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode sequencer: holds the state register and latched
// opcode, computes the next state, and delegates the control word to cs_decode.
module control_unit
  import cpu_pkg::*;
#(
  parameter int SZ = CS_W
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [7:0]    ibus,
  input  logic          mem_ready,
  input  logic          zf,
  output logic [SZ-1:0] CS_bus,
  output logic          halt
);

  state_e     state_q, state_d;
  logic [3:0] opcode_q, opcode_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_BOOT;
      opcode_q <= OP_NOP;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    unique case (state_q)
      ST_BOOT:   state_d = ST_FETCH0;
      ST_FETCH0: state_d = ST_FETCH1;
      ST_FETCH1: begin
        if (mem_ready) begin
          opcode_d = ibus[7:4];
          state_d  = ST_DECODE;
        end
      end
      // zf is consulted here only; a later flag change cannot redirect a JZ.
      ST_DECODE: begin
        if (opcode_q == OP_HLT)                state_d = ST_HALT;
        else if (skips_operand(opcode_q, zf))  state_d = ST_FETCH0;
        else                                   state_d = ST_OPRD;
      end
      ST_OPRD: begin
        if (mem_ready) state_d = needs_wb(opcode_q) ? ST_WB : ST_FETCH0;
      end
      ST_WB:   state_d = ST_FETCH0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  cs_decode #(.SZ(SZ)) u_cs_decode (
    .state     (state_q),
    .opcode    (opcode_q),
    .zf        (zf),
    .mem_ready (mem_ready),
    .cs_bus    (CS_bus),
    .halt      (halt)
  );

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: each instruction is expanded into its
// expected per-cycle control words from the instruction-level timing rules.
module tb_control_unit;

  localparam int SZ = 28;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [7:0]    ibus = 8'h00;
  logic          mem_ready = 1'b0;
  logic          zf = 1'b0;
  logic [SZ-1:0] CS_bus;
  logic          halt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          mr;
    logic [7:0]    ib;
    logic          zfv;
    logic [SZ-1:0] cs;
    logic          h;
  } cyc_t;

  cyc_t q[$];

  control_unit #(.SZ(SZ)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .ibus      (ibus),
    .mem_ready (mem_ready),
    .zf        (zf),
    .CS_bus    (CS_bus),
    .halt      (halt)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [SZ-1:0] obs, input logic [SZ-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [SZ-1:0] bitv(input int n);
    return SZ'(1) << n;
  endfunction

  function automatic cyc_t mk(input logic mr, input logic [7:0] ib, input logic zfv,
                              input logic [SZ-1:0] cs, input logic h);
    cyc_t c;
    c.mr = mr; c.ib = ib; c.zfv = zfv; c.cs = cs; c.h = h;
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [7:0] rbyte();
    return 8'($urandom);
  endfunction

  // Instruction-level model: fetch, optional wait states, decode, operand, writeback.
  task automatic build(input logic [3:0] opc, input logic zd, input int w1, input int w2);
    logic [SZ-1:0] opbit;
    logic          skip;
    q.delete();
    q.push_back(mk(rb(), rbyte(), rb(), bitv(6) | bitv(9), 1'b0));
    for (int i = 0; i < w1; i++) q.push_back(mk(1'b0, rbyte(), rb(), bitv(10), 1'b0));
    q.push_back(mk(1'b1, {opc, 4'($urandom)}, rb(), bitv(10) | bitv(11) | bitv(7), 1'b0));
    if (opc == 4'hF) begin
      q.push_back(mk(rb(), rbyte(), zd, '0, 1'b0));
      for (int i = 0; i < 4; i++) q.push_back(mk(rb(), rbyte(), rb(), '0, 1'b1));
      return;
    end
    skip = (opc == 4'h0) || (opc >= 4'hA && opc <= 4'hE) || (opc == 4'h9 && !zd);
    if (skip) begin
      q.push_back(mk(rb(), rbyte(), zd, bitv(7), 1'b0));
      return;
    end
    q.push_back(mk(rb(), rbyte(), zd, bitv(6) | bitv(9), 1'b0));
    for (int i = 0; i < w2; i++) q.push_back(mk(1'b0, rbyte(), rb(), bitv(10), 1'b0));
    case (opc)
      4'h1:    opbit = bitv(0);
      4'h2:    opbit = bitv(2);
      4'h3:    opbit = bitv(1);
      4'h4:    opbit = bitv(3);
      4'h5:    opbit = bitv(4);
      4'h6:    opbit = bitv(5);
      4'h7:    opbit = bitv(12);
      default: opbit = bitv(8);
    endcase
    q.push_back(mk(1'b1, rbyte(), rb(), bitv(10) | bitv(7) | opbit, 1'b0));
    if (opc inside {4'h1, 4'h2, 4'h4, 4'h5, 4'h6})
      q.push_back(mk(rb(), rbyte(), rb(), bitv(25) | bitv(12), 1'b0));
  endtask

  task automatic release_and_boot();
    @(negedge CLK);
    RST_N = 1'b1;
    #2;
    check_val("cs_boot", CS_bus, '0);
    check_val("halt_boot", {{(SZ-1){1'b0}}, halt}, '0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0;
    #2;
    check_val("cs_rst", CS_bus, '0);
    check_val("halt_rst", {{(SZ-1){1'b0}}, halt}, '0);
    release_and_boot();
  endtask

  // Plays the queued cycles; abort_idx >= 0 pulls reset partway through that cycle.
  task automatic run(input string name, input int abort_idx, output logic aborted);
    aborted = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge CLK);
      mem_ready = q[i].mr;
      ibus      = q[i].ib;
      zf        = q[i].zfv;
      #2;
      check_val({name, "_cs"}, CS_bus, q[i].cs);
      check_val({name, "_halt"}, {{(SZ-1){1'b0}}, halt}, {{(SZ-1){1'b0}}, q[i].h});
      if (i == abort_idx) begin
        #1 RST_N = 1'b0;
        #1;
        check_val({name, "_abort_cs"}, CS_bus, '0);
        check_val({name, "_abort_halt"}, {{(SZ-1){1'b0}}, halt}, '0);
        release_and_boot();
        aborted = 1'b1;
        return;
      end
    end
  endtask

  task automatic instr(input string name, input logic [3:0] opc, input logic zd,
                       input int w1, input int w2, input int abort_idx);
    logic ab;
    build(opc, zd, w1, w2);
    run(name, abort_idx, ab);
    if (opc == 4'hF && !ab) do_reset();
  endtask

  initial begin
    int   w1, w2, ab;
    logic [3:0] opc;
    RST_N = 1'b0;
    #2;
    check_val("cs_por", CS_bus, '0);
    check_val("halt_por", {{(SZ-1){1'b0}}, halt}, '0);
    release_and_boot();

    instr("add",       4'h1, 1'b0, 0, 0, -1);
    instr("cmp",       4'h3, 1'b1, 0, 0, -1);
    instr("jz_taken",  4'h9, 1'b1, 0, 0, -1);
    instr("jz_not",    4'h9, 1'b0, 0, 0, -1);
    instr("add_wait",  4'h1, 1'b0, 0, 3, -1);
    instr("sub_abort", 4'h2, 1'b0, 0, 2, 3);
    instr("ldi",       4'h7, 1'b0, 2, 1, -1);
    instr("jmp",       4'h8, 1'b0, 0, 0, -1);
    instr("nop",       4'h0, 1'b1, 1, 0, -1);
    instr("op_b",      4'hB, 1'b0, 0, 0, -1);
    instr("xor",       4'h4, 1'b1, 0, 0, -1);
    instr("and",       4'h5, 1'b0, 1, 1, -1);
    instr("or",        4'h6, 1'b1, 0, 2, -1);
    instr("hlt",       4'hF, 1'b0, 0, 0, -1);

    for (int n = 0; n < 300; n++) begin
      opc = 4'($urandom);
      w1  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      w2  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      build(opc, rb(), w1, w2);
      ab  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, q.size() - 1) : -1;
      begin
        logic aborted;
        run("rnd", ab, aborted);
        if (opc == 4'hF && !aborted) do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
